bp_fe_ras_multi: RTL
====================

Name: bp_fe_ras_multi

Overview:
- Parametrised multi-entry return address stack (RAS) for the multi-issue front end; replaces the single-register return-address latch in pc_gen.
- Scans a fetch group of slots_p instructions per cycle and applies at most one call/return (first control slot wins).
- Supplies the predicted return target and a per-fetch checkpoint that travels in branch metadata.
- Restores from that checkpoint on backend redirect.

Parameters:
- vaddr_width_p, 39, virtual address width.
- depth_p, 8, stack entries; power of two, >= 2.
- slots_p, 2, instructions per fetch group; slot k pc = fetch_pc_i + 4*k.
- ptr_width_lp, derived, $clog2(depth_p).
- cnt_width_lp, derived, $clog2(depth_p+1).
- ckpt_width_lp, derived, ptr_width_lp + cnt_width_lp.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- fetch_v_i  in  1  fetch group valid, accepted this cycle.
- fetch_pc_i  in  vaddr_width_p  pc of slot 0.
- call_i  in  slots_p  per-slot call flag from instr scan.
- ret_i  in  slots_p  per-slot return flag from instr scan.
- tgt_o  out  vaddr_width_p  top-of-stack return target.
- tgt_v_o  out  1  stack non-empty.
- ckpt_o  out  ckpt_width_lp  {tos_ptr, count} before this cycle's update, for metadata.
- restore_v_i  in  1  backend redirect restore.
- restore_ckpt_i  in  ckpt_width_lp  checkpoint to restore.
- restore_call_i  in  1  redirecting instr is a call.
- restore_ret_i  in  1  redirecting instr is a return.
- restore_pc_i  in  vaddr_width_p  pc of redirecting instr.
- count_o  out  cnt_width_lp  live entry count.
- full_o  out  1  count == depth_p.
- overflow_o  out  1  one-cycle pulse when a push overwrites the oldest entry.

Behaviour:
- State: mem[depth_p] of vaddr_width_p, tos_ptr, count.
- Reset (async, reset_n_i=0): tos_ptr=0, count=0, all mem=0. Outputs: tgt_o=0, tgt_v_o=0, ckpt_o=0, count_o=0, full_o=0, overflow_o=0.
- tgt_o = mem[tos_ptr] and tgt_v_o = (count!=0), both combinational from state. A return consumes the pre-update value in the same cycle.
- Slot select: k = lowest index with call_i[k]|ret_i[k]. Slots above k are ignored. No slot flagged -> no-op.
- Push (call only): tos_ptr+1 mod depth_p, mem[new ptr] = fetch_pc_i + 4*(k+1), count = min(count+1, depth_p).
- Pop (ret only): if count>0 then tos_ptr-1 mod depth_p and count-1. If count==0, no change (underflow is silent, tgt_v_o stays 0).
- Call and return in the same slot: replace mem[tos_ptr] with the new address, tos_ptr unchanged. Count = max(count,1).
- Overflow: a push at count==depth_p wraps, overwrites the oldest entry, keeps count=depth_p, and pulses overflow_o for one cycle.
- Updates are registered: a push is visible on tgt_o the next cycle.
- restore_v_i=1 takes priority; fetch activity that cycle is dropped.
  - tos_ptr and count load from restore_ckpt_i.
  - The restore_call_i / restore_ret_i operation is then applied against the restored state, using return address restore_pc_i+4 and the same push/pop/replace rules.
  - Entry contents are not restored; entries overwritten on the wrong path stay corrupted, which is an accepted accuracy loss.
- Address arithmetic is modulo 2^vaddr_width_p with the carry dropped.
- Restored count > depth_p: illegal input; assert in simulation.
- fetch_v_i=0: call_i and ret_i are ignored.

Decomposition:
- bp_fe_pkg holds the checkpoint struct bp_fe_ras_ckpt_s {ptr, cnt}, width macro-declared, plus the ras op enum e_ras_nop/push/pop/replace.
- One sub-module, bp_fe_ras_op_sel: priority encoder over slots_p producing op enum and slot index.
- Stack storage and pointers are inline flops; no SRAM.

Test Plan:
1. Reset mid-operation: push 3 calls, assert reset_n_i low asynchronously between edges -> count_o=0, tgt_v_o=0, tgt_o=0 immediately, without waiting for a clock edge.
2. fetch_pc_i=0x1000, call_i=2'b10 -> next cycle tgt_o=0x1008, count_o=1. Then ret_i=2'b01 -> tgt_o reads 0x1008 that cycle, count_o=0 next cycle.
3. call_i=2'b11, ret_i=2'b00 at pc 0x2000 -> single push of 0x2004 (slot 0 wins), count_o=1.
4. depth_p=8: push 9 calls at pcs 0x100..0x900 step 0x100 -> overflow_o pulses on the 9th push, count_o=8. Eight pops return 0x904 down to 0x204, then tgt_v_o=0. A ninth pop is a no-op.
5. Push 0xA04 and 0xB04, capture ckpt_o, push 0xC04, pop twice. Then restore_v_i with that checkpoint plus restore_call_i at restore_pc_i=0xD00, with fetch call_i also set -> fetch call dropped, tgt_o=0xD04, count_o=3.
6. Replace: count=0, call_i[0]=ret_i[0]=1 at pc 0x3000 -> tgt_o=0x3004, count_o=1. Repeat at pc 0x4000 -> tgt_o=0x4004, count_o=1.

Source files
------------

// File: rtl/bp_fe_pkg.sv
// Front-end shared types: RAS checkpoint struct declaration macro and RAS op enum.
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

// Checkpoint width depends on the instantiating stack's depth, so the struct
// is declared inside the user module through this macro.
`define BP_FE_DECLARE_RAS_CKPT_S(ptr_w, cnt_w) \
  typedef struct packed {                      \
    logic [ptr_w-1:0] ptr;                     \
    logic [cnt_w-1:0] cnt;                     \
  } bp_fe_ras_ckpt_s;

package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_ras_nop     = 2'b00,
    e_ras_push    = 2'b01,
    e_ras_pop     = 2'b10,
    e_ras_replace = 2'b11
  } bp_fe_ras_op_e;

  // Byte distance between consecutive instruction slots in a fetch group
  localparam int unsigned ras_slot_bytes_lp = 4;

endpackage

`endif

// File: rtl/bp_fe_ras_op_sel.sv
// Priority encoder over a fetch group: first slot flagged as call or return wins.
module bp_fe_ras_op_sel
  import bp_fe_pkg::*;
  #(parameter  int unsigned slots_p       = 2,
    localparam int unsigned slot_width_lp = (slots_p > 1) ? $clog2(slots_p) : 1)
  (input  logic                     v_i,
   input  logic [slots_p-1:0]       call_i,
   input  logic [slots_p-1:0]       ret_i,
   output bp_fe_ras_op_e            op_o,
   output logic [slot_width_lp-1:0] slot_o);

  logic found;

  // Lowest flagged slot selects the op; later slots are ignored
  always_comb begin
    op_o   = e_ras_nop;
    slot_o = '0;
    found  = 1'b0;
    if (v_i) begin
      for (int unsigned i = 0; i < slots_p; i++) begin
        if (!found && (call_i[i] || ret_i[i])) begin
          found  = 1'b1;
          slot_o = slot_width_lp'(i);
          unique case ({call_i[i], ret_i[i]})
            2'b10:   op_o = e_ras_push;
            2'b01:   op_o = e_ras_pop;
            2'b11:   op_o = e_ras_replace;
            default: op_o = e_ras_nop;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/bp_fe_ras_multi.sv
// Multi-entry return address stack with per-fetch checkpoint and redirect restore.
module bp_fe_ras_multi
  import bp_fe_pkg::*;
  #(parameter  int unsigned vaddr_width_p = 39,
    parameter  int unsigned depth_p       = 8,
    parameter  int unsigned slots_p       = 2,
    localparam int unsigned ptr_width_lp  = $clog2(depth_p),
    localparam int unsigned cnt_width_lp  = $clog2(depth_p+1),
    localparam int unsigned ckpt_width_lp = ptr_width_lp + cnt_width_lp)
  (input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     fetch_v_i,
   input  logic [vaddr_width_p-1:0] fetch_pc_i,
   input  logic [slots_p-1:0]       call_i,
   input  logic [slots_p-1:0]       ret_i,
   output logic [vaddr_width_p-1:0] tgt_o,
   output logic                     tgt_v_o,
   output logic [ckpt_width_lp-1:0] ckpt_o,
   input  logic                     restore_v_i,
   input  logic [ckpt_width_lp-1:0] restore_ckpt_i,
   input  logic                     restore_call_i,
   input  logic                     restore_ret_i,
   input  logic [vaddr_width_p-1:0] restore_pc_i,
   output logic [cnt_width_lp-1:0]  count_o,
   output logic                     full_o,
   output logic                     overflow_o);

  `BP_FE_DECLARE_RAS_CKPT_S(ptr_width_lp, cnt_width_lp)

  localparam int unsigned slot_width_lp = (slots_p > 1) ? $clog2(slots_p) : 1;
  localparam logic [cnt_width_lp-1:0] depth_cnt_lp = cnt_width_lp'(depth_p);

  logic [vaddr_width_p-1:0] mem [depth_p];
  logic [ptr_width_lp-1:0]  tos_ptr, ptr_n, base_ptr;
  logic [cnt_width_lp-1:0]  count, cnt_n, base_cnt;
  logic                     ovf_n, wr_en;
  logic [ptr_width_lp-1:0]  wr_idx;
  logic [vaddr_width_p-1:0] ret_addr;

  bp_fe_ras_ckpt_s          ckpt_cur, ckpt_rst;
  bp_fe_ras_op_e            fetch_op, op;
  logic [slot_width_lp-1:0] fetch_slot;

  bp_fe_ras_op_sel #(.slots_p(slots_p)) op_sel
    (.v_i(fetch_v_i), .call_i(call_i), .ret_i(ret_i), .op_o(fetch_op), .slot_o(fetch_slot));

  assign ckpt_cur = '{ptr: tos_ptr, cnt: count};
  assign ckpt_rst = restore_ckpt_i;
  assign ckpt_o   = ckpt_cur;
  assign tgt_o    = mem[tos_ptr];
  assign tgt_v_o  = (count != '0);
  assign count_o  = count;
  assign full_o   = (count == depth_cnt_lp);

  // Restore rebases pointer/count first, then the same push/pop/replace rules apply
  always_comb begin
    base_ptr = tos_ptr;
    base_cnt = count;
    op       = fetch_op;
    ret_addr = fetch_pc_i
             + vaddr_width_p'((32'(fetch_slot) + 32'd1) * ras_slot_bytes_lp);
    if (restore_v_i) begin
      base_ptr = ckpt_rst.ptr;
      base_cnt = ckpt_rst.cnt;
      ret_addr = restore_pc_i + vaddr_width_p'(ras_slot_bytes_lp);
      unique case ({restore_call_i, restore_ret_i})
        2'b10:   op = e_ras_push;
        2'b01:   op = e_ras_pop;
        2'b11:   op = e_ras_replace;
        default: op = e_ras_nop;
      endcase
    end

    ptr_n  = base_ptr;
    cnt_n  = base_cnt;
    ovf_n  = 1'b0;
    wr_en  = 1'b0;
    wr_idx = base_ptr;
    unique case (op)
      e_ras_push: begin
        ptr_n  = base_ptr + 1'b1;
        wr_en  = 1'b1;
        wr_idx = base_ptr + 1'b1;
        if (base_cnt == depth_cnt_lp) ovf_n = 1'b1;
        else                          cnt_n = base_cnt + 1'b1;
      end
      e_ras_pop: begin
        if (base_cnt != '0) begin
          ptr_n = base_ptr - 1'b1;
          cnt_n = base_cnt - 1'b1;
        end
      end
      e_ras_replace: begin
        wr_en = 1'b1;
        if (base_cnt == '0) cnt_n = cnt_width_lp'(1);
      end
      default: ;
    endcase
  end

  // Pointer, count and overflow pulse registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tos_ptr    <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      tos_ptr    <= ptr_n;
      count      <= cnt_n;
      overflow_o <= ovf_n;
    end
  end

  // Stack storage; entries are never rolled back on restore
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < depth_p; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= ret_addr;
    end
  end

  a_restore_cnt_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    restore_v_i |-> (ckpt_rst.cnt <= depth_cnt_lp));

endmodule
